// File: rtl/stat_dump_if.sv
// Byte-stream valid/ready link between stat_dump and its downstream sink.
// master drives data/valid, slave drives ready.
interface stat_dump_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/stat_dump.sv
// stat_dump: snapshots the R/I/J/TotalCycles counters on request and streams them as a byte frame.
// Define STAT_DUMP_CHECKSUM_EN to append an XOR checksum byte after the 16 data bytes.
module stat_dump #(
   parameter logic [7:0] HEADER = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] R,
   input  logic [31:0] I,
   input  logic [31:0] J,
   input  logic [31:0] TotalCycles,
   input  logic        req,
   stat_dump_if.master bus,
   output logic        busy,
   output logic        done
);

`ifdef STAT_DUMP_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;
   logic [7:0] acc;
`else
   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif

   state_t      state;
   logic [3:0]  idx;
   logic [31:0] snap_r;
   logic [31:0] snap_i;
   logic [31:0] snap_j;
   logic [31:0] snap_t;
   logic [3:0]  sel;
   logic [31:0] word;
   logic [7:0]  next_byte;

   // The byte to present after the current transfer: data byte 0 when leaving HDR,
   // otherwise the byte following idx, MSB first within each word.
   always_comb begin
      sel = (state == DATA) ? idx + 4'd1 : 4'd0;
      case (sel[3:2])
         2'd0:    word = snap_r;
         2'd1:    word = snap_i;
         2'd2:    word = snap_j;
         default: word = snap_t;
      endcase
      next_byte = word[{~sel[1:0], 3'b000} +: 8];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         idx           <= 4'd0;
         snap_r        <= 32'd0;
         snap_i        <= 32'd0;
         snap_j        <= 32'd0;
         snap_t        <= 32'd0;
         bus.out_data  <= 8'd0;
         bus.out_valid <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
`ifdef STAT_DUMP_CHECKSUM_EN
         acc           <= 8'd0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  snap_r        <= R;
                  snap_i        <= I;
                  snap_j        <= J;
                  snap_t        <= TotalCycles;
                  idx           <= 4'd0;
                  state         <= HDR;
                  bus.out_valid <= 1'b1;
                  bus.out_data  <= HEADER;
                  busy          <= 1'b1;
`ifdef STAT_DUMP_CHECKSUM_EN
                  acc           <= 8'd0;
`endif
               end
            end
            HDR: begin
               if (bus.out_ready) begin
                  state        <= DATA;
                  idx          <= 4'd0;
                  bus.out_data <= next_byte;
               end
            end
            DATA: begin
               if (bus.out_ready) begin
`ifdef STAT_DUMP_CHECKSUM_EN
                  acc <= acc ^ bus.out_data;
`endif
                  if (idx == 4'd15) begin
`ifdef STAT_DUMP_CHECKSUM_EN
                     state         <= CSUM;
                     bus.out_data  <= acc ^ bus.out_data;
`else
                     state         <= IDLE;
                     bus.out_valid <= 1'b0;
                     bus.out_data  <= 8'd0;
                     busy          <= 1'b0;
                     done          <= 1'b1;
`endif
                  end else begin
                     idx          <= idx + 4'd1;
                     bus.out_data <= next_byte;
                  end
               end
            end
`ifdef STAT_DUMP_CHECKSUM_EN
            CSUM: begin
               if (bus.out_ready) begin
                  state         <= IDLE;
                  bus.out_valid <= 1'b0;
                  bus.out_data  <= 8'd0;
                  busy          <= 1'b0;
                  done          <= 1'b1;
               end
            end
`endif
            default: begin
               state         <= IDLE;
               bus.out_valid <= 1'b0;
               busy          <= 1'b0;
            end
         endcase
      end
   end

endmodule
